// File: rtl/posit_decode_pipe.sv
// Purpose: parametrised posit decoder -> sign, zero/NaR flags, signed scale, MSB-aligned fraction.
// Latency: 3 cycles from accepted input to out_valid; one decode per cycle sustained.
// Backpressure: global stall while out_valid && !out_ready; every stage holds and in_ready drops.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_posit is the raw NBITS-wide posit pattern
//   out_valid/out_ready   output handshake
//   out_sign              sign bit of the input posit
//   out_zero, out_nar     input was all zeros / input was 1 followed by zeros
//   out_scale             signed regime*2^ES + exponent (0 for zero and NaR)
//   out_frac              fraction without hidden bit, MSB-aligned, zero-padded (0 for zero and NaR)
module posit_decode_pipe #(
  parameter int NBITS = 16,
  parameter int ES    = 1,
  parameter int SW    = $clog2(NBITS) + ES + 2,
  parameter int FW    = NBITS - 3 - ES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBITS-1:0]     in_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic signed [SW-1:0] out_scale,
  output logic [FW-1:0]        out_frac
);

  localparam int BW = NBITS - 1;      // body bits (everything below the sign)
  localparam int TW = BW - 2;         // body bits that can survive the shortest regime (== ES + FW)
  localparam int KW = $clog2(NBITS);  // holds run lengths up to BW
  localparam int RW = KW + 1;         // signed regime width
  localparam int EW = (ES > 0) ? ES : 1;

  // Global stall: the whole pipe freezes when the output register cannot drain.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------------------------------------------------------- S1
  logic          s1_vld;
  logic          s1_sign;
  logic          s1_zero;
  logic          s1_nar;
  logic [BW-1:0] s1_body;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_nar  <= 1'b0;
      s1_body <= '0;
    end else if (!stall) begin
      s1_vld  <= in_valid;
      s1_sign <= in_posit[NBITS-1];
      s1_zero <= (in_posit == '0);
      s1_nar  <= in_posit[NBITS-1] && (in_posit[BW-1:0] == '0);
      // Negative posits decode as the magnitude of their two's complement.
      s1_body <= in_posit[NBITS-1] ? -in_posit[BW-1:0] : in_posit[BW-1:0];
    end
  end

  // ---------------------------------------------------------------- S2
  // Run length of the leading body bit; a run always has length >= 1.
  logic          run_bit;
  logic          run_end;
  logic [KW-1:0] run_len;
  logic [RW-1:0] regime_nxt;

  always_comb begin
    run_bit = s1_body[BW-1];
    run_len = '0;
    run_end = 1'b0;
    for (int i = BW - 1; i >= 0; i--) begin
      if (!run_end && (s1_body[i] == run_bit)) begin
        run_len = run_len + KW'(1);
      end else begin
        run_end = 1'b1;
      end
    end
    regime_nxt = run_bit ? ({1'b0, run_len} - RW'(1)) : -{1'b0, run_len};
  end

  logic                 s2_vld;
  logic                 s2_sign;
  logic                 s2_zero;
  logic                 s2_nar;
  logic signed [RW-1:0] s2_regime;
  logic [KW-1:0]        s2_shamt;
  logic [TW-1:0]        s2_tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_nar    <= 1'b0;
      s2_regime <= '0;
      s2_shamt  <= '0;
      s2_tail   <= '0;
    end else if (!stall) begin
      s2_vld    <= s1_vld;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_nar    <= s1_nar;
      s2_regime <= regime_nxt;
      // Dropping run+terminator (k+1 bits) from the body is the same as dropping
      // k-1 bits from the body with its top two bits already removed.
      s2_shamt  <= run_len - KW'(1);
      s2_tail   <= s1_body[TW-1:0];
    end
  end

  // ---------------------------------------------------------------- S3
  // A run that fills the body shifts everything out, giving exp = 0 and frac = 0.
  logic [TW-1:0]        tail_shift;
  logic [EW-1:0]        exp_bits;
  logic [FW-1:0]        frac_nxt;
  logic signed [SW-1:0] regime_sx;
  logic signed [SW-1:0] scale_nxt;
  logic                 special;

  assign tail_shift = s2_tail << s2_shamt;
  assign frac_nxt   = tail_shift[FW-1:0];
  assign special    = s2_zero || s2_nar;

  if (ES > 0) begin : g_exp
    assign exp_bits = tail_shift[TW-1:FW];
  end else begin : g_no_exp
    assign exp_bits = '0;
  end

  // The low ES bits of regime*2^ES are zero, so the exponent can be ORed in.
  assign regime_sx = SW'(s2_regime);
  assign scale_nxt = (regime_sx <<< ES) | SW'(exp_bits);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_nar   <= 1'b0;
      out_scale <= '0;
      out_frac  <= '0;
    end else if (!stall) begin
      out_valid <= s2_vld;
      out_sign  <= s2_sign;
      out_zero  <= s2_zero;
      out_nar   <= s2_nar;
      out_scale <= special ? '0 : scale_nxt;
      out_frac  <= special ? '0 : frac_nxt;
    end
  end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Purpose: self-checking bench for posit_decode_pipe (16/1 main instance, 8/0 and 32/2 sweep instances).
// Latency: checks the 3-cycle accepted-input to out_valid latency.
// Backpressure: exercises stalls, mid-stream async reset and random out_ready.
module tb_posit_decode_pipe;

  localparam int SW16 = 7;
  localparam int FW16 = 12;
  localparam int SW8  = 5;
  localparam int FW8  = 5;
  localparam int SW32 = 9;
  localparam int FW32 = 27;

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic               nar;
    logic signed [31:0] scale;
    logic [31:0]        frac;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // main 16/1 instance
  logic                   m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [15:0]            m_in_posit;
  logic                   m_out_sign, m_out_zero, m_out_nar;
  logic signed [SW16-1:0] m_out_scale;
  logic [FW16-1:0]        m_out_frac;

  // sweep 8/0 instance
  logic                   s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
  logic [7:0]             s8_in_posit;
  logic                   s8_out_sign, s8_out_zero, s8_out_nar;
  logic signed [SW8-1:0]  s8_out_scale;
  logic [FW8-1:0]         s8_out_frac;

  // sweep 32/2 instance
  logic                   s32_in_valid, s32_in_ready, s32_out_valid, s32_out_ready;
  logic [31:0]            s32_in_posit;
  logic                   s32_out_sign, s32_out_zero, s32_out_nar;
  logic signed [SW32-1:0] s32_out_scale;
  logic [FW32-1:0]        s32_out_frac;

  posit_decode_pipe #(.NBITS(16), .ES(1)) u_m (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_posit(m_in_posit),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_sign(m_out_sign), .out_zero(m_out_zero), .out_nar(m_out_nar),
    .out_scale(m_out_scale), .out_frac(m_out_frac)
  );

  posit_decode_pipe #(.NBITS(8), .ES(0)) u_s8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s8_in_valid), .in_ready(s8_in_ready), .in_posit(s8_in_posit),
    .out_valid(s8_out_valid), .out_ready(s8_out_ready),
    .out_sign(s8_out_sign), .out_zero(s8_out_zero), .out_nar(s8_out_nar),
    .out_scale(s8_out_scale), .out_frac(s8_out_frac)
  );

  posit_decode_pipe #(.NBITS(32), .ES(2)) u_s32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s32_in_valid), .in_ready(s32_in_ready), .in_posit(s32_in_posit),
    .out_valid(s32_out_valid), .out_ready(s32_out_ready),
    .out_sign(s32_out_sign), .out_zero(s32_out_zero), .out_nar(s32_out_nar),
    .out_scale(s32_out_scale), .out_frac(s32_out_frac)
  );

  // Reference decoder: walks the posit bit by bit as the number format defines it.
  function automatic exp_t ref_decode(input longint unsigned p_in, input int n, input int es);
    longint unsigned mask, p, v;
    int   idx, k, regime, expo, rem, fw, b;
    exp_t r;
    mask = (64'd1 << n) - 64'd1;
    p    = p_in & mask;
    r    = '0;
    r.sign = ((p >> (n - 1)) & 64'd1) != 0;
    if (p == 0) begin
      r.zero = 1'b1;
    end else if (p == (64'd1 << (n - 1))) begin
      r.nar = 1'b1;
    end else begin
      v   = r.sign ? (((64'd1 << n) - p) & mask) : p;
      idx = n - 2;
      b   = int'((v >> idx) & 64'd1);
      k   = 0;
      while (idx >= 0 && int'((v >> idx) & 64'd1) == b) begin
        k++;
        idx--;
      end
      regime = (b == 1) ? k - 1 : -k;
      idx--;  // terminator
      expo = 0;
      for (int j = 0; j < es; j++) begin
        expo = expo * 2 + ((idx >= 0) ? int'((v >> idx) & 64'd1) : 0);
        idx--;
      end
      fw  = n - 3 - es;
      rem = (idx + 1 > 0) ? idx + 1 : 0;
      r.frac  = 32'((v & ((64'd1 << rem) - 64'd1)) << (fw - rem));
      r.scale = regime * (1 << es) + expo;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    m_in_valid = 1'b0;  m_in_posit = '0;  m_out_ready = 1'b1;
    s8_in_valid = 1'b0; s8_in_posit = '0; s8_out_ready = 1'b1;
    s32_in_valid = 1'b0; s32_in_posit = '0; s32_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({m_out_valid, m_in_ready, m_out_sign, m_out_zero, m_out_nar, m_out_scale, m_out_frac}
        !== {1'b0, 1'b1, 3'b000, 7'd0, 12'd0}) begin
      n_bad++;
      $display("FAIL reset_main: got v=%b rdy=%b s=%b z=%b n=%b sc=%0d fr=%h, want v=0 rdy=1 all data 0",
               m_out_valid, m_in_ready, m_out_sign, m_out_zero, m_out_nar, m_out_scale, m_out_frac);
    end
    n_vec++;
    if ({s8_out_valid, s32_out_valid, s8_in_ready, s32_in_ready} !== 4'b0011) begin
      n_bad++;
      $display("FAIL reset_sweep: got v8=%b v32=%b r8=%b r32=%b, want 0 0 1 1",
               s8_out_valid, s32_out_valid, s8_in_ready, s32_in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] pat   [7] = '{16'h4000, 16'h5A00, 16'hC000, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000};
    int          sc    [7] = '{0, 1, 0, 28, -28, 0, 0};
    logic [11:0] fr    [7] = '{12'h000, 12'hA00, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    logic [2:0]  flags [7] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b010, 3'b101};
    int lat;
    m_out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      m_in_posit = pat[t];
      m_in_valid = 1'b1;
      @(negedge clk);
      m_in_valid = 1'b0;
      m_in_posit = 16'($urandom);  // ignored while in_valid is low
      lat = 1;
      while (!m_out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      n_vec++;
      if (lat !== 3 || m_out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL dir_latency[%h]: got %0d cycles (valid=%b), want 3", pat[t], lat, m_out_valid);
      end
      n_vec++;
      if ({m_out_sign, m_out_zero, m_out_nar, int'(m_out_scale), m_out_frac}
          !== {flags[t], sc[t], fr[t]}) begin
        n_bad++;
        $display("FAIL dir_value[%h]: got s/z/n=%b%b%b scale=%0d frac=%h, want %b scale=%0d frac=%h",
                 pat[t], m_out_sign, m_out_zero, m_out_nar, m_out_scale, m_out_frac,
                 flags[t], sc[t], fr[t]);
      end
      @(negedge clk);
      n_vec++;
      if (m_out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL dir_single[%h]: got out_valid=%b after result, want 0", pat[t], m_out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat [3] = '{16'h4000, 16'h5A00, 16'h7FFF};
    int          sc  [3] = '{0, 1, 28};
    logic [11:0] fr  [3] = '{12'h000, 12'hA00, 12'h000};
    m_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_in_valid = 1'b1;
      m_in_posit = pat[i];
      @(negedge clk);
    end
    m_in_valid = 1'b0;
    n_vec++;
    if (m_out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_first_valid: got %b, want 1", m_out_valid);
    end
    m_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if ({m_in_ready, m_out_valid, int'(m_out_scale), m_out_frac} !== {1'b0, 1'b1, 32'sd0, 12'h000}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b scale=%0d frac=%h, want rdy=0 v=1 scale=0 frac=000",
                 c, m_in_ready, m_out_valid, m_out_scale, m_out_frac);
      end
      @(negedge clk);
    end
    m_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({m_out_valid, int'(m_out_scale), m_out_frac} !== {1'b1, sc[i], fr[i]}) begin
        n_bad++;
        $display("FAIL bp_drain[%0d]: got v=%b scale=%0d frac=%h, want v=1 scale=%0d frac=%h",
                 i, m_out_valid, m_out_scale, m_out_frac, sc[i], fr[i]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (m_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_no_extra: got out_valid=%b, want 0", m_out_valid);
    end
  endtask

  task automatic test_async_reset();
    int stale = 0;
    int lat;
    m_out_ready = 1'b1;
    m_in_valid  = 1'b1;
    m_in_posit  = 16'h7FFF;
    @(negedge clk);
    m_in_posit  = 16'h0001;
    @(negedge clk);
    m_in_valid  = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: got out_valid=%b, want 1", m_out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({m_out_valid, m_in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL arst_drop: got v=%b rdy=%b, want v=0 rdy=1", m_out_valid, m_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (m_out_valid) stale++;
    end
    n_vec++;
    if (stale !== 0) begin
      n_bad++;
      $display("FAIL arst_stale: got %0d stale valid cycles, want 0", stale);
    end
    m_in_valid = 1'b1;
    m_in_posit = 16'h5A00;
    @(negedge clk);
    m_in_valid = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if ({lat, int'(m_out_scale), m_out_frac} !== {32'sd3, 32'sd1, 12'hA00}) begin
      n_bad++;
      $display("FAIL arst_after: got lat=%0d scale=%0d frac=%h, want lat=3 scale=1 frac=a00",
               lat, m_out_scale, m_out_frac);
    end
    @(negedge clk);
  endtask

  task automatic test_random_stream();
    exp_t q [$];
    exp_t act;
    int   cyc = 0;
    while ((cyc < 500 || q.size() != 0) && cyc < 700) begin
      if (m_out_valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rnd_unexpected: got out_valid with nothing outstanding, want none");
        end else begin
          act = {m_out_sign, m_out_zero, m_out_nar, int'(m_out_scale), 32'(m_out_frac)};
          if (act !== q[0]) begin
            n_bad++;
            $display("FAIL rnd_value: got %h, want %h", act, q[0]);
          end
        end
      end
      m_out_ready = (cyc >= 500) || ($urandom_range(0, 3) != 0);
      m_in_valid  = (cyc < 500) && ($urandom_range(0, 9) < 7);
      m_in_posit  = 16'($urandom);
      #1;
      if (m_out_valid && m_out_ready && q.size() != 0) void'(q.pop_front());
      if (m_in_valid && m_in_ready) q.push_back(ref_decode(64'(m_in_posit), 16, 1));
      @(negedge clk);
      cyc++;
    end
    m_in_valid = 1'b0;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_drain: got %0d results outstanding, want 0", q.size());
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0]  stim8  [$];
    logic [31:0] stim32 [$];
    exp_t q8 [$];
    exp_t q32 [$];
    exp_t act;
    int i8 = 0;
    int i32 = 0;
    int cyc = 0;
    for (int v = 0; v < 256; v++) stim8.push_back(8'(v));
    for (int r = 1; r <= 31; r++) begin
      longint unsigned rnd, body1, body0, sgn;
      rnd = {$urandom, $urandom};
      sgn = longint'($urandom_range(0, 1)) << 31;
      if (r < 31) begin
        body1 = (((64'd1 << r) - 64'd1) << (31 - r)) | (rnd & ((64'd1 << (30 - r)) - 64'd1));
        body0 = (64'd1 << (30 - r)) | (rnd & ((64'd1 << (30 - r)) - 64'd1));
      end else begin
        body1 = (64'd1 << 31) - 64'd1;
        body0 = 64'd0;
      end
      stim32.push_back(32'(sgn | body1));
      stim32.push_back(32'((sgn ^ (64'd1 << 31)) | body0));
    end
    repeat (200) stim32.push_back($urandom);
    while ((i8 < stim8.size() || i32 < stim32.size() || q8.size() != 0 || q32.size() != 0)
           && cyc < 4000) begin
      if (s8_out_valid) begin
        n_vec++;
        act = {s8_out_sign, s8_out_zero, s8_out_nar, int'(s8_out_scale), 32'(s8_out_frac)};
        if (q8.size() == 0 || act !== q8[0]) begin
          n_bad++;
          $display("FAIL sweep8: got %h, want %h (outstanding %0d)", act,
                   (q8.size() != 0) ? q8[0] : exp_t'('0), q8.size());
        end
      end
      if (s32_out_valid) begin
        n_vec++;
        act = {s32_out_sign, s32_out_zero, s32_out_nar, int'(s32_out_scale), 32'(s32_out_frac)};
        if (q32.size() == 0 || act !== q32[0]) begin
          n_bad++;
          $display("FAIL sweep32: got %h, want %h (outstanding %0d)", act,
                   (q32.size() != 0) ? q32[0] : exp_t'('0), q32.size());
        end
      end
      s8_out_ready  = ($urandom_range(0, 4) != 0);
      s32_out_ready = ($urandom_range(0, 4) != 0);
      s8_in_valid   = (i8 < stim8.size());
      s32_in_valid  = (i32 < stim32.size());
      s8_in_posit   = s8_in_valid ? stim8[i8] : 8'($urandom);
      s32_in_posit  = s32_in_valid ? stim32[i32] : $urandom;
      #1;
      if (s8_out_valid && s8_out_ready && q8.size() != 0) void'(q8.pop_front());
      if (s32_out_valid && s32_out_ready && q32.size() != 0) void'(q32.pop_front());
      if (s8_in_valid && s8_in_ready) begin
        q8.push_back(ref_decode(64'(s8_in_posit), 8, 0));
        i8++;
      end
      if (s32_in_valid && s32_in_ready) begin
        q32.push_back(ref_decode(64'(s32_in_posit), 32, 2));
        i32++;
      end
      @(negedge clk);
      cyc++;
    end
    s8_in_valid  = 1'b0;
    s32_in_valid = 1'b0;
    n_vec++;
    if (cyc >= 4000 || q8.size() != 0 || q32.size() != 0) begin
      n_bad++;
      $display("FAIL sweep_drain: got cyc=%0d left8=%0d left32=%0d, want all drained",
               cyc, q8.size(), q32.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random_stream();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
